// File: rtl/seq_stage30_sync_fifo_if.sv
// Handshake bundle for seq_stage30_sync_fifo.
//   in_valid/in_ready/in_data     : producer side (write)
//   out_valid/out_ready/out_data  : consumer side (read, registered)
//   level                         : words held (memory rows + output register)
// modport slave  : the FIFO itself
// modport master : whatever drives the FIFO (producer and consumer together)
interface seq_stage30_sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 2);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    level;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/seq_stage30_sync_fifo.sv
// Synchronous FIFO: DEPTH-row memory with one write port and one synchronous
// read port feeding a registered output stage. Capacity is DEPTH+1 words.
// Ports:
//   clk   : clock, all updates on posedge
//   rst_n : asynchronous reset, active-low (pointers, count, output stage)
//   bus   : seq_stage30_sync_fifo_if.slave
//           in_valid/in_ready/in_data, out_valid/out_ready/out_data, level
module seq_stage30_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_stage30_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 2);
  localparam int MW = AW + 1;            // mem_count must reach DEPTH

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [MW-1:0]    mem_count_q, mem_count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic in_ready;
  logic push;
  logic load;
  logic ostage_free;

  always_comb begin
    // in_ready comes from registered state only; a pop does not free a slot
    // for a push in the same cycle.
    in_ready    = (mem_count_q != MW'(DEPTH));
    push        = bus.in_valid & in_ready;
    ostage_free = !out_valid_q | bus.out_ready;
    load        = ostage_free & (mem_count_q != '0);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // Pointers wrap naturally: DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (load) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_data_d  = mem[rd_ptr_q];
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      // Word consumed and nothing to replace it; out_data keeps its value.
      out_valid_d = 1'b0;
    end

    unique case ({push, load})
      2'b10:   mem_count_d = mem_count_q + MW'(1);
      2'b01:   mem_count_d = mem_count_q - MW'(1);
      default: mem_count_d = mem_count_q;
    endcase
  end

  // Memory rows are never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifndef SYNTHESIS
      assert (mem_count_q <= MW'(DEPTH));
      if (bus.in_valid && !in_ready)
        $display("fifo overflow attempt d=%0d", bus.in_data);
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.level     = CW'(mem_count_q) + CW'(out_valid_q);
endmodule

// File: tb/tb_seq_stage30_sync_fifo.sv
module tb_seq_stage30_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_stage30_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  seq_stage30_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed at the posedge following a negedge where
  // out_valid & out_ready both hold; compare it with the scoreboard head.
  initial begin
    logic [WIDTH-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got %0h want none", bus.out_data);
        end else begin
          exp = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(exp));
        end
      end
    end
  end

  // Inputs change on the negedge; acceptance is known from registered in_ready.
  task automatic offer(input logic [WIDTH-1:0] d, input logic r, output logic acc);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = r;
    acc = bus.in_ready;
    if (acc) sb.push_back(d);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.level != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_level", 32'(bus.level), 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"},     32'(bus.level), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"},  32'(bus.out_data), 0);
    chk({tag, "_in_ready"},  32'(bus.in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n, cyc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Power-on reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("por");

    // Reset mid-stream with five words held
    for (int i = 1; i <= 5; i++) offer(WIDTH'(i), 1'b0, acc);
    bus.in_valid = 1'b0;
    chk("mid_level_before", 32'(bus.level), 5);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("mid_level_in_reset", 32'(bus.level), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("mid");

    // Latency: push A5 with consumer ready
    offer(8'hA5, 1'b1, acc);
    bus.in_valid = 1'b0;
    chk("lat_e_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_e1_out_valid", 32'(bus.out_valid), 1);
    chk("lat_e1_out_data", 32'(bus.out_data), 32'hA5);
    @(negedge clk);
    chk("lat_e2_out_valid", 32'(bus.out_valid), 0);

    // Fill with consumer stalled: 17 words fit
    for (int i = 0; i <= 16; i++) begin
      chk("fill_in_ready", 32'(bus.in_ready), 1);
      offer(WIDTH'(i), 1'b0, acc);
    end
    chk("fill_level", 32'(bus.level), 17);
    chk("fill_in_ready_full", 32'(bus.in_ready), 0);
    offer(8'hFF, 1'b0, acc);
    bus.in_valid = 1'b0;
    chk("fill_ff_ignored", 32'(bus.level), 17);

    // Full with simultaneous pop and push attempt
    chk("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h20;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("full_in_ready_back", 32'(bus.in_ready), 1);
    chk("full_level_after_pop", 32'(bus.level), 16);
    sb.push_back(8'h20);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();

    // Wrap: 40 words with random consumer stalls
    n = 0;
    cyc = 0;
    while (n < 40 && cyc < 1000) begin
      offer(WIDTH'(n * 3), 1'($urandom_range(0, 1)), acc);
      if (acc) n++;
      cyc++;
    end
    chk("wrap_accepted", 32'(n), 40);
    drain();

    // Continuous push/pop from empty: level settles between 1 and 2
    for (int i = 0; i < 10; i++) begin
      offer(WIDTH'(8'h50 + i), 1'b1, acc);
      chk("pp_level_range", 32'((bus.level >= 1) && (bus.level <= 2)), 1);
    end
    drain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
